// File: rtl/stopwatch_ctrl.sv
`timescale 1ns/1ps
// stopwatch_ctrl
//   MM:SS stopwatch controller with run/pause/clear buttons and an optional
//   lap (display freeze) feature.
//
//   Optional feature macro: STOPWATCH_LAP_EN
//     defined   : a lap edge in RUN or PAUSE toggles a display freeze that
//                 shows a snapshot while counting continues internally.
//     undefined : lap is ignored and the outputs always show live digits.
//
// Parameters
//   TICK_DIV    clk cycles per counted second (>= 2)
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-low reset
//   start_stop  debounced button; rising edge toggles run/pause
//   clear       debounced button; rising edge returns to idle from pause
//   lap         debounced button; rising edge toggles display freeze
//   sec_lo/sec_hi/min_lo/min_hi  displayed BCD digits
//   running     high while in RUN (registered)
//   overflow    sticky, set on the 59:59 -> 00:00 wrap
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] sec_lo,
    output logic [3:0] sec_hi,
    output logic [3:0] min_lo,
    output logic [3:0] min_hi,
    output logic       running,
    output logic       overflow
);

    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          armed_q, armed_d;
    logic          start_btn_q, start_btn_d;
    logic          clear_btn_q, clear_btn_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    sec_lo_q, sec_lo_d;
    logic [3:0]    sec_hi_q, sec_hi_d;
    logic [3:0]    min_lo_q, min_lo_d;
    logic [3:0]    min_hi_q, min_hi_d;
    logic          overflow_q, overflow_d;
    logic          running_q, running_d;

    logic start_edge;
    logic clear_edge;
    logic enter_idle;
    logic sec_tick;

    // The first clock after reset release only loads the button registers,
    // so a button held through reset release never looks like an edge.
    assign armed_d     = 1'b1;
    assign start_btn_d = start_stop;
    assign clear_btn_d = clear;
    assign start_edge  = armed_q & start_stop & ~start_btn_q;
    assign clear_edge  = armed_q & clear & ~clear_btn_q;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_edge) state_d = RUN;
            RUN:     if (start_edge) state_d = PAUSE;
            PAUSE: begin
                if (clear_edge)      state_d = IDLE;
                else if (start_edge) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    assign enter_idle = (state_q != IDLE) && (state_d == IDLE);
    assign running_d  = (state_d == RUN);

    // Prescaler: advances only in RUN, holds in PAUSE
    assign sec_tick = (state_q == RUN) && (presc_q == PRESC_MAX);

    always_comb begin
        presc_d = presc_q;
        if (enter_idle) begin
            presc_d = '0;
        end else if (state_q == RUN) begin
            presc_d = sec_tick ? '0 : presc_q + PW'(1);
        end
    end

    // Digit cascade; '>=' comparisons keep digits inside their range even
    // from an out-of-range value.
    always_comb begin
        sec_lo_d   = sec_lo_q;
        sec_hi_d   = sec_hi_q;
        min_lo_d   = min_lo_q;
        min_hi_d   = min_hi_q;
        overflow_d = overflow_q;
        if (enter_idle) begin
            sec_lo_d   = '0;
            sec_hi_d   = '0;
            min_lo_d   = '0;
            min_hi_d   = '0;
            overflow_d = 1'b0;
        end else if (sec_tick) begin
            if (sec_lo_q < 4'd9) begin
                sec_lo_d = sec_lo_q + 4'd1;
            end else begin
                sec_lo_d = '0;
                if (sec_hi_q < 4'd5) begin
                    sec_hi_d = sec_hi_q + 4'd1;
                end else begin
                    sec_hi_d = '0;
                    if (min_lo_q < 4'd9) begin
                        min_lo_d = min_lo_q + 4'd1;
                    end else begin
                        min_lo_d = '0;
                        if (min_hi_q < 4'd5) begin
                            min_hi_d = min_hi_q + 4'd1;
                        end else begin
                            min_hi_d   = '0;
                            overflow_d = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            armed_q     <= 1'b0;
            start_btn_q <= 1'b0;
            clear_btn_q <= 1'b0;
            presc_q     <= '0;
            sec_lo_q    <= '0;
            sec_hi_q    <= '0;
            min_lo_q    <= '0;
            min_hi_q    <= '0;
            overflow_q  <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            start_btn_q <= start_btn_d;
            clear_btn_q <= clear_btn_d;
            presc_q     <= presc_d;
            sec_lo_q    <= sec_lo_d;
            sec_hi_q    <= sec_hi_d;
            min_lo_q    <= min_lo_d;
            min_hi_q    <= min_hi_d;
            overflow_q  <= overflow_d;
            running_q   <= running_d;
        end
    end

    assign running  = running_q;
    assign overflow = overflow_q;

`ifdef STOPWATCH_LAP_EN
    logic        lap_btn_q, lap_btn_d;
    logic        freeze_q, freeze_d;
    logic [15:0] snap_q, snap_d;
    logic        lap_edge;

    assign lap_btn_d = lap;
    assign lap_edge  = armed_q & lap & ~lap_btn_q;

    // Snapshot holds the digits visible at the lap edge that sets freeze.
    always_comb begin
        freeze_d = freeze_q;
        snap_d   = snap_q;
        if (enter_idle) begin
            freeze_d = 1'b0;
        end else if (lap_edge && (state_q != IDLE)) begin
            freeze_d = ~freeze_q;
            if (!freeze_q) begin
                snap_d = {min_hi_q, min_lo_q, sec_hi_q, sec_lo_q};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lap_btn_q <= 1'b0;
            freeze_q  <= 1'b0;
            snap_q    <= '0;
        end else begin
            lap_btn_q <= lap_btn_d;
            freeze_q  <= freeze_d;
            snap_q    <= snap_d;
        end
    end

    always_comb begin
        if (freeze_q) begin
            {min_hi, min_lo, sec_hi, sec_lo} = snap_q;
        end else begin
            {min_hi, min_lo, sec_hi, sec_lo} = {min_hi_q, min_lo_q, sec_hi_q, sec_lo_q};
        end
    end
`else
    logic lap_unused;
    assign lap_unused = lap;

    always_comb begin
        {min_hi, min_lo, sec_hi, sec_lo} = {min_hi_q, min_lo_q, sec_hi_q, sec_lo_q};
    end
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
`timescale 1ns/1ps
module tb_stopwatch_ctrl;

    localparam int TICK_DIV = 4;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start_stop, clear, lap;
    logic [3:0] sec_lo, sec_hi, min_lo, min_hi;
    logic       running, overflow;

    stopwatch_ctrl #(.TICK_DIV(TICK_DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_stop(start_stop),
        .clear     (clear),
        .lap       (lap),
        .sec_lo    (sec_lo),
        .sec_hi    (sec_hi),
        .min_lo    (min_lo),
        .min_hi    (min_hi),
        .running   (running),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: elapsed time kept as a plain seconds count.
    int m_mode;     // 0 idle, 1 run, 2 pause
    int m_phase;    // clk cycles into the current second
    int m_secs;     // 0..3599
    int m_snap;     // seconds shown while frozen
    bit m_ovf, m_frozen, m_armed;
    bit m_prev_s, m_prev_c, m_prev_l;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [15:0] to_bcd(input int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic [15:0] shown();
        return {min_hi, min_lo, sec_hi, sec_lo};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_phase = 0; m_secs = 0; m_snap = 0;
        m_ovf = 0; m_frozen = 0; m_armed = 0;
        m_prev_s = 0; m_prev_c = 0; m_prev_l = 0;
    endtask

    task automatic model_step();
        bit se, ce, le, tick;
        if (!rst) begin
            model_reset();
            return;
        end
        se = m_armed && start_stop && !m_prev_s;
        ce = m_armed && clear && !m_prev_c;
        le = m_armed && lap && !m_prev_l;
        tick = (m_mode == 1) && (m_phase == TICK_DIV - 1);
        if (m_mode == 1) m_phase = (m_phase + 1) % TICK_DIV;
        if (LAP_EN && le && m_mode != 0) begin
            if (!m_frozen) m_snap = m_secs;
            m_frozen = !m_frozen;
        end
        if (tick) begin
            if (m_secs == 3599) m_ovf = 1;
            m_secs = (m_secs + 1) % 3600;
        end
        case (m_mode)
            0: if (se) m_mode = 1;
            1: if (se) m_mode = 2;
            default: begin
                if (ce) begin
                    m_mode = 0; m_secs = 0; m_phase = 0; m_ovf = 0; m_frozen = 0;
                end else if (se) begin
                    m_mode = 1;
                end
            end
        endcase
        m_prev_s = start_stop;
        m_prev_c = clear;
        m_prev_l = lap;
        m_armed  = 1;
    endtask

    task automatic compare_model();
        check_eq("digits", shown(), to_bcd(m_frozen ? m_snap : m_secs));
        check_eq("running", 16'(running), 16'(m_mode == 1));
        check_eq("overflow", 16'(overflow), 16'(m_ovf));
    endtask

    // One clock: model advances on the edge, DUT checked on the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        rst = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
        model_reset();
        #1;
        check_eq("reset_digits", shown(), 16'h0000);
        check_eq("reset_running", 16'(running), 16'h0);
        check_eq("reset_overflow", 16'(overflow), 16'h0);
        @(negedge clk);
        rst = 1'b1;
        cyc();

        // Count 10 seconds
        start_stop = 1; cyc(); start_stop = 0;
        run(40);
        check_eq("run40_digits", shown(), 16'h0010);
        check_eq("run40_running", 16'(running), 16'h1);
        check_eq("run40_overflow", 16'(overflow), 16'h0);

        // Pause at 00:03, hold, resume with preserved phase
        start_stop = 1; cyc(); start_stop = 0; cyc();
        clear = 1; cyc(); clear = 0;
        start_stop = 1; cyc(); start_stop = 0;
        run(12);
        check_eq("at3_digits", shown(), 16'h0003);
        start_stop = 1; cyc();
        run(20);
        check_eq("pause_digits", shown(), 16'h0003);
        check_eq("pause_running", 16'(running), 16'h0);
        start_stop = 0; cyc();
        start_stop = 1; cyc(); start_stop = 0;
        run(2);
        check_eq("resume_phase_hold", shown(), 16'h0003);
        run(1);
        check_eq("resume_phase_step", shown(), 16'h0004);

        // Clear and start rising together in PAUSE
        start_stop = 1; cyc(); start_stop = 0; cyc();
        clear = 1; start_stop = 1; cyc();
        check_eq("clear_prio_digits", shown(), 16'h0000);
        check_eq("clear_prio_running", 16'(running), 16'h0);
        clear = 0; start_stop = 0; cyc();

        // Wrap 59:59 -> 00:00
        start_stop = 1; cyc(); start_stop = 0;
        run(14392);
        check_eq("at5958_digits", shown(), 16'h5958);
        check_eq("at5958_overflow", 16'(overflow), 16'h0);
        run(8);
        check_eq("wrap_digits", shown(), 16'h0000);
        check_eq("wrap_overflow", 16'(overflow), 16'h1);
        check_eq("wrap_running", 16'(running), 16'h1);
        start_stop = 1; cyc(); start_stop = 0;
        clear = 1; cyc(); clear = 0;
        check_eq("clear_overflow", 16'(overflow), 16'h0);
        cyc();

        // Lap freeze
        start_stop = 1; cyc(); start_stop = 0;
        run(20);
        lap = 1; cyc(); lap = 0;
        run(12);
        check_eq("lap_frozen", shown(), LAP_EN ? 16'h0005 : 16'h0008);
        lap = 1; cyc();
        check_eq("lap_release", shown(), 16'h0008);
        lap = 0; cyc();

        // Asynchronous reset mid-RUN, start held through release
        start_stop = 1; cyc(); start_stop = 0; cyc();
        clear = 1; cyc(); clear = 0;
        start_stop = 1; cyc(); start_stop = 0;
        run(28);
        check_eq("at7_digits", shown(), 16'h0007);
        #2;
        rst = 1'b0; start_stop = 1;
        #1;
        check_eq("async_rst_digits", shown(), 16'h0000);
        check_eq("async_rst_running", 16'(running), 16'h0);
        check_eq("async_rst_overflow", 16'(overflow), 16'h0);
        model_reset();
        run(2);
        rst = 1'b1;
        run(6);
        check_eq("held_start_running", 16'(running), 16'h0);
        check_eq("held_start_digits", shown(), 16'h0000);
        start_stop = 0; cyc();

        // Randomized buttons and occasional async reset against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom % 8 == 0) start_stop = ~start_stop;
            if ($urandom % 10 == 0) clear = ~clear;
            if ($urandom % 6 == 0) lap = ~lap;
            if ($urandom % 600 == 0) begin
                #2 rst = 1'b0;
                #1;
                check_eq("rand_rst_digits", shown(), 16'h0000);
                check_eq("rand_rst_running", 16'(running), 16'h0);
                model_reset();
                run(2);
                rst = 1'b1;
            end
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
